// File: rtl/full_adder_behavioral.sv
// Behavioral WIDTH-bit full adder: combinational sum/carry plus a registered,
// chainable result stage for word-serial multi-word addition (LS word first).
module full_adder_behavioral #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             chain,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             overflow_q,
    output logic             out_valid
);

    logic             cin_eff;
    logic [WIDTH:0]   full_sum;
    logic             ovf;

    // The stored carry feeds back here, so a chained beat reads the old carry_q.
    always_comb begin
        cin_eff   = chain ? carry_q : carry_in;
        full_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
        sum       = full_sum[WIDTH-1:0];
        carry_out = full_sum[WIDTH];
        ovf       = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q      <= sum;
                carry_q    <= carry_out;
                overflow_q <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Directed self-checking bench: one WIDTH=1 and one WIDTH=8 instance.
module tb_full_adder_behavioral;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a1, b1, cin1, chain1, iv1;
    logic       sum1, cout1, sum_q1, cq1, ovq1, ov1;

    logic [7:0] a8, b8, sum8, sum_q8;
    logic       cin8, chain8, iv8, cout8, cq8, ovq8, ov8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder_behavioral #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(cin1), .chain(chain1),
        .in_valid(iv1), .sum(sum1), .carry_out(cout1), .sum_q(sum_q1),
        .carry_q(cq1), .overflow_q(ovq1), .out_valid(ov1)
    );

    full_adder_behavioral #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(cin8), .chain(chain8),
        .in_valid(iv8), .sum(sum8), .carry_out(cout8), .sum_q(sum_q8),
        .carry_q(cq8), .overflow_q(ovq8), .out_valid(ov8)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // sum/carry_out for (a,b,cin) = 000..111
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] v;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;

        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; chain1 = 1'b0; iv1 = 1'b1;
        a8 = '0; b8 = '0; cin8 = 1'b0; chain8 = 1'b0; iv8 = 1'b0;

        step();
        check("rst_sum_q",  {8'h0, sum_q1}, 9'h0);
        check("rst_carry_q", {8'h0, cq1},   9'h0);
        check("rst_ovf_q",  {8'h0, ovq1},   9'h0);
        check("rst_out_valid", {8'h0, ov1}, 9'h0);
        check("rst_comb_sum", {cout1, 7'h0, sum1}, 9'h100);
        check("rst_w8_sum_q", {cq8, sum_q8}, 9'h000);

        rst_n = 1'b1;
        step();
        check("rel_sum_q",   {8'h0, sum_q1}, 9'h0);
        check("rel_carry_q", {8'h0, cq1},    9'h1);
        check("rel_ovf_q",   {8'h0, ovq1},   9'h1);
        check("rel_out_valid", {8'h0, ov1},  9'h1);

        iv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            #1;
            check($sformatf("sweep_%0d", i), {cout1, 7'h0, sum1}, {exp_c[i], 7'h0, exp_s[i]});
        end

        // carry_q held at 1 since in_valid has been low
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; chain1 = 1'b1;
        #1;
        check("w1_chain_comb", {cout1, 7'h0, sum1}, 9'h001);

        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; chain8 = 1'b0; iv8 = 1'b1;
        step();
        check("chain_b1", {cq8, sum_q8}, 9'h100);
        check("chain_b1_valid", {8'h0, ov8}, 9'h1);
        a8 = 8'h12; b8 = 8'h34; chain8 = 1'b1;
        step();
        check("chain_b2", {cq8, sum_q8}, 9'h047);

        chain8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
        step();
        check("ovf_7f_01", {ovq8, cq8, 7'h0}, 9'h100);
        check("ovf_7f_01_sum", {1'b0, sum_q8}, 9'h080);
        a8 = 8'h80; b8 = 8'h80;
        step();
        check("ovf_80_80", {ovq8, cq8, 7'h0}, 9'h180);
        check("ovf_80_80_sum", {1'b0, sum_q8}, 9'h000);
        a8 = 8'hFF; b8 = 8'h01;
        step();
        check("ovf_ff_01", {ovq8, cq8, 7'h0}, 9'h080);

        iv8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(8'h11 * (i + 1)); b8 = 8'(8'h22 * (i + 1)); chain8 = 1'(i);
            step();
            check($sformatf("hold_%0d", i), {cq8, sum_q8}, 9'h100);
            check($sformatf("hold_ovf_%0d", i), {ovq8, 7'h0, ov8}, 9'h000);
        end
        a8 = 8'h01; b8 = 8'h02; chain8 = 1'b1; iv8 = 1'b1;
        step();
        check("hold_chain", {cq8, sum_q8}, 9'h004);

        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; chain8 = 1'b0;
        step();
        check("pre_rst_beat", {cq8, sum_q8}, 9'h1FF);
        rst_n = 1'b0; iv8 = 1'b0;
        step();
        check("mid_rst", {cq8, sum_q8}, 9'h000);
        rst_n = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; chain8 = 1'b1; iv8 = 1'b1;
        step();
        check("post_rst_chain", {cq8, sum_q8}, 9'h002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
